// File: rtl/color_balance_pipe.sv
// color_balance_pipe: per-channel RGB gain with round-half-up and saturation, gains committed at frame_start.
// Define COLOR_BALANCE_STATS_EN to build the per-frame channel-sum statistics unit.
module color_balance_pipe #(
    parameter int DATA_W = 8,
    parameter int GAIN_W = 10,
    parameter int FRAC_W = 6,
    parameter int SUM_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3*DATA_W-1:0] rgb_in,
    input  logic                rgb_in_valid,
    input  logic                frame_start,
    input  logic [GAIN_W-1:0]   gain_r,
    input  logic [GAIN_W-1:0]   gain_g,
    input  logic [GAIN_W-1:0]   gain_b,
    input  logic                gain_load,
    output logic [3*DATA_W-1:0] rgb_out,
    output logic                rgb_out_valid,
    output logic                gain_pending,
    output logic [SUM_W-1:0]    stat_sum_r,
    output logic [SUM_W-1:0]    stat_sum_g,
    output logic [SUM_W-1:0]    stat_sum_b,
    output logic                stat_valid
);
    localparam int PW = DATA_W + GAIN_W;
    typedef enum logic {IDLE, PENDING} state_e;
    state_e              state_q, state_d;
    logic [GAIN_W-1:0]   act_q [3];
    logic [GAIN_W-1:0]   act_d [3];
    logic [GAIN_W-1:0]   pend_q [3];
    logic [GAIN_W-1:0]   pend_d [3];
    logic [GAIN_W-1:0]   gin [3];
    logic [DATA_W-1:0]   pix [3];
    logic [DATA_W-1:0]   res [3];
    logic [PW:0]         q [3];
    logic [PW-1:0]       p_q [3];
    logic                v1_q, v2_q;
    logic [3*DATA_W-1:0] out_q;
    assign gin[0] = gain_r;
    assign gin[1] = gain_g;
    assign gin[2] = gain_b;
    assign gain_pending  = (state_q == PENDING);
    assign rgb_out       = out_q;
    assign rgb_out_valid = v2_q;
    // act_d doubles as the gain seen by the pixel sampled this cycle
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        pend_d  = pend_q;
        if (gain_load) begin
            pend_d  = gin;
            state_d = PENDING;
        end
        if (frame_start) begin
            state_d = IDLE;
            if (gain_load) act_d = gin;
            else if (state_q == PENDING) act_d = pend_q;
        end
    end
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            pix[c] = rgb_in[(2-c)*DATA_W +: DATA_W];
            q[c]   = ({1'b0, p_q[c]} + (PW+1)'(1 << (FRAC_W-1))) >> FRAC_W;
            res[c] = |q[c][PW:DATA_W] ? '1 : q[c][DATA_W-1:0];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            out_q   <= '0;
            for (int c = 0; c < 3; c++) begin
                act_q[c]  <= GAIN_W'(1 << FRAC_W);
                pend_q[c] <= GAIN_W'(1 << FRAC_W);
                p_q[c]    <= '0;
            end
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            v1_q    <= rgb_in_valid;
            v2_q    <= v1_q;
            out_q   <= v1_q ? {res[0], res[1], res[2]} : '0;
            for (int c = 0; c < 3; c++) p_q[c] <= PW'(pix[c]) * PW'(act_d[c]);
        end
    end
`ifdef COLOR_BALANCE_STATS_EN
    logic [SUM_W-1:0] acc_q [3];
    logic [SUM_W-1:0] acc_d [3];
    logic [SUM_W-1:0] sum_q [3];
    logic [SUM_W:0]   add [3];
    logic             sv_q;
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            add[c]   = {1'b0, acc_q[c]} + (SUM_W+1)'(pix[c]);
            acc_d[c] = frame_start ? (rgb_in_valid ? SUM_W'(pix[c]) : '0) :
                       rgb_in_valid ? (add[c][SUM_W] ? '1 : add[c][SUM_W-1:0]) : acc_q[c];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sv_q <= 1'b0;
            for (int c = 0; c < 3; c++) begin
                acc_q[c] <= '0;
                sum_q[c] <= '0;
            end
        end else begin
            sv_q  <= frame_start;
            acc_q <= acc_d;
            if (frame_start) sum_q <= acc_q;
        end
    end
    assign stat_sum_r = sum_q[0];
    assign stat_sum_g = sum_q[1];
    assign stat_sum_b = sum_q[2];
    assign stat_valid = sv_q;
`else
    assign stat_sum_r = '0;
    assign stat_sum_g = '0;
    assign stat_sum_b = '0;
    assign stat_valid = 1'b0;
`endif
endmodule
